// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD result collector.
// Optional threshold statistics are enabled with SAD_COLLECT_THRESH_EN.
package sad_pkg;
  localparam int SAD_W          = 32;
  localparam int IDX_W          = 7;
  localparam int NUM_BLOCKS_MAX = 128;
  // Counts run 0..NUM_BLOCKS_MAX inclusive, so one extra bit over the index.
  localparam int CNT_W          = $clog2(NUM_BLOCKS_MAX) + 1;

  localparam logic [SAD_W-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} ctl_state_t;
  typedef enum logic       {W_IDLE = 1'b0, W_REQ = 1'b1} wr_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [SAD_W-1:0] sad;
  } sad_entry_t;
endpackage

// File: rtl/sad_result_collector_if.sv
// Handshake, memory and status bundle of the SAD result collector.
// SAD_COLLECT_THRESH_EN adds thresh / hit_count / hit.
interface sad_result_collector_if;
  import sad_pkg::*;

  logic             start;
  logic [CNT_W-1:0] num_blocks;
  logic             in_valid;
  logic [SAD_W-1:0] in_sad;
  logic [IDX_W-1:0] in_idx;
  logic             in_ready;
  logic [IDX_W-1:0] o_addr;
  logic [SAD_W-1:0] o_data;
  logic             o_rw;
  logic             o_en;
  logic             o_ack;
  logic             busy;
  logic             done;
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
`ifdef SAD_COLLECT_THRESH_EN
  logic [SAD_W-1:0] thresh;
  logic [7:0]       hit_count;
  logic             hit;

  modport slave (input  start, num_blocks, in_valid, in_sad, in_idx, o_ack, thresh,
                 output in_ready, o_addr, o_data, o_rw, o_en, busy, done,
                        best_sad, best_idx, hit_count, hit);
  modport master (output start, num_blocks, in_valid, in_sad, in_idx, o_ack, thresh,
                  input  in_ready, o_addr, o_data, o_rw, o_en, busy, done,
                         best_sad, best_idx, hit_count, hit);
`else
  modport slave (input  start, num_blocks, in_valid, in_sad, in_idx, o_ack,
                 output in_ready, o_addr, o_data, o_rw, o_en, busy, done,
                        best_sad, best_idx);
  modport master (output start, num_blocks, in_valid, in_sad, in_idx, o_ack,
                  input  in_ready, o_addr, o_data, o_rw, o_en, busy, done,
                         best_sad, best_idx);
`endif
endinterface

// File: rtl/sad_result_fifo.sv
// Small synchronous FIFO buffering {idx, sad} results ahead of the memory writer.
// DEPTH must be a power of two so the pointers wrap naturally.
module sad_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 39
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = count[PW];
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  // Storage array; contents need no reset, the count qualifies them.
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
endmodule

// File: rtl/sad_result_collector.sv
// Collects per-block SAD results, writes them to result memory and reports
// the best (minimum) match once every block of the frame has been stored.
// SAD_COLLECT_THRESH_EN adds a below-threshold hit counter and flag.
module sad_result_collector
  import sad_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sad_result_collector_if.slave  bus
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  ctl_state_t       state;
  wr_state_t        wstate;
  logic [CNT_W-1:0] nb_q, acc_cnt, wr_cnt, acc_nxt;
  logic [FCW-1:0]   f_cnt, f_cnt_nxt;
  logic             accept, bypass, push, pop, wr_done, f_full, f_empty;
  sad_entry_t       in_ent, head;

  assign accept    = bus.in_valid && bus.in_ready;
  // An idle writer with nothing queued takes the result straight from the input,
  // so the request goes out the cycle after the accept edge.
  assign bypass    = accept && (wstate == W_IDLE) && f_empty;
  assign push      = accept && !bypass && !f_full;
  assign pop       = (wstate == W_IDLE) && !f_empty;
  assign wr_done   = (wstate == W_REQ) && bus.o_ack;
  assign in_ent    = {bus.in_idx, bus.in_sad};
  assign f_cnt_nxt = f_cnt + FCW'(push) - FCW'(pop);
  assign acc_nxt   = acc_cnt + CNT_W'(accept);

  sad_result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(sad_entry_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_ent),
    .rdata (head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  // Frame control: counters, minimum tracking, ready and status outputs.
  // in_ready looks at next-cycle occupancy/count so it never over-accepts.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      nb_q         <= '0;
      acc_cnt      <= '0;
      wr_cnt       <= '0;
      bus.in_ready <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.best_sad <= SAD_MAX;
      bus.best_idx <= '0;
    end else begin
      bus.done <= 1'b0;
      if (accept)  acc_cnt <= acc_nxt;
      if (wr_done) wr_cnt  <= wr_cnt + 1'b1;
      if (accept && (bus.in_sad < bus.best_sad)) begin
        bus.best_sad <= bus.in_sad;
        bus.best_idx <= bus.in_idx;
      end
      case (state)
        IDLE: if (bus.start) begin
          nb_q         <= bus.num_blocks;
          acc_cnt      <= '0;
          wr_cnt       <= '0;
          bus.best_sad <= SAD_MAX;
          bus.best_idx <= '0;
          bus.busy     <= 1'b1;
          if (bus.num_blocks == '0) begin
            state <= FIN;
          end else begin
            state        <= RUN;
            bus.in_ready <= 1'b1;
          end
        end
        RUN: if (wr_cnt == nb_q) begin
          state        <= FIN;
          bus.in_ready <= 1'b0;
        end else begin
          bus.in_ready <= (f_cnt_nxt < FCW'(FIFO_DEPTH)) && (acc_nxt < nb_q);
        end
        FIN: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

  // Memory writer: one request at a time, held stable until acknowledged.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wstate     <= W_IDLE;
      bus.o_en   <= 1'b0;
      bus.o_rw   <= 1'b0;
      bus.o_addr <= '0;
      bus.o_data <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (!f_empty) begin
          bus.o_addr <= head.idx;
          bus.o_data <= head.sad;
          bus.o_en   <= 1'b1;
          bus.o_rw   <= 1'b1;
          wstate     <= W_REQ;
        end else if (accept) begin
          bus.o_addr <= bus.in_idx;
          bus.o_data <= bus.in_sad;
          bus.o_en   <= 1'b1;
          bus.o_rw   <= 1'b1;
          wstate     <= W_REQ;
        end
        W_REQ: if (bus.o_ack) begin
          bus.o_en <= 1'b0;
          bus.o_rw <= 1'b0;
          wstate   <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end

`ifdef SAD_COLLECT_THRESH_EN
  // Below-threshold statistics over accepted results, cleared on Start.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.hit_count <= '0;
      bus.hit       <= 1'b0;
    end else if ((state == IDLE) && bus.start) begin
      bus.hit_count <= '0;
      bus.hit       <= 1'b0;
    end else if (accept && (bus.in_sad < bus.thresh)) begin
      bus.hit_count <= bus.hit_count + 1'b1;
      bus.hit       <= 1'b1;
    end
`endif
endmodule

// File: doc/sad_result_collector.md
Name: sad_result_collector

Overview:
- Sits directly downstream of the SAD engine.
- Accepts one 32-bit SAD result per block over a valid/ready handshake and buffers results in a small FIFO.
- Writes each result to the 128-entry result memory.
- Tracks the minimum SAD and its block index, then pulses Done with the best match once all blocks are stored.

Parameters:
- FIFO_DEPTH, 4, result buffer entries (power of two, 2..16)
- IDX_W, 7, block index / result memory address width
- SAD_W, 32, SAD value width

Ports:
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  begin a frame; sampled only in IDLE
- Num_Blocks  in  8  blocks expected this frame (0..128); latched on Start
- In_Valid  in  1  SAD result present
- In_SAD  in  SAD_W  SAD value
- In_Idx  in  IDX_W  block index of the result
- In_Ready  out  1  collector can accept
- O_Addr  out  IDX_W  result memory address
- O_Data  out  SAD_W  result memory write data
- O_RW  out  1  1 = write; always 1 while O_En is high
- O_En  out  1  memory request
- O_Ack  in  1  memory completed the current request
- Busy  out  1  frame in progress
- Done  out  1  one-cycle pulse at frame end
- Best_SAD  out  SAD_W  minimum SAD of the frame
- Best_Idx  out  IDX_W  index of the minimum SAD

Behaviour:
- Reset values (async on Rst_n low):
  - In_Ready, O_En, O_RW, Busy, Done = 0
  - O_Addr, O_Data, Best_Idx = 0
  - Best_SAD = all ones
  - FIFO empty; accept and write counters = 0
  - Both FSMs in their idle states
- Control FSM states: IDLE, RUN, FIN.
  - IDLE, Start=1: latch Num_Blocks, Best_SAD <= all ones, Best_Idx <= 0, clear counters, go RUN, Busy=1.
  - IDLE, Start=1 with Num_Blocks=0: go FIN directly.
  - RUN: when write count == latched Num_Blocks, go FIN.
  - FIN: Done=1 for exactly one cycle, Busy=0, go IDLE.
  - Start outside IDLE is ignored.
- In_Ready (registered):
  - Equals RUN && !fifo_full && accept_count < Num_Blocks.
  - Is 0 in IDLE and FIN.
- Accept: In_Valid && In_Ready at a rising edge pushes {In_Idx, In_SAD} and increments accept_count.
- Minimum tracking:
  - Updated on the accept edge, using strict less-than.
  - Ties keep the earlier-accepted index.
  - Best_SAD and Best_Idx are valid from the Done cycle and hold until the next Start.
- Writer FSM states: W_IDLE, W_REQ.
  - W_IDLE, FIFO non-empty: pop head, drive O_Addr=idx, O_Data=sad, O_En=1, O_RW=1, go W_REQ.
  - W_REQ: hold O_En, O_Addr and O_Data stable until O_Ack=1.
  - On the O_Ack edge: O_En=0, write_count+1, back to W_IDLE.
  - O_En is therefore low for at least one cycle between requests.
- Latency:
  - Earliest O_En is the cycle after the accept edge.
  - Done is asserted 2 cycles after the O_Ack edge of the final write (count update, then FIN).
- FIFO boundaries:
  - A simultaneous push and pop is legal, except that no push occurs while full, because In_Ready is registered from the full flag.
  - Pointers wrap modulo FIFO_DEPTH.
- O_Ack outside W_REQ is ignored.
- Duplicate In_Idx values are written as given; no deduplication.
- Rst_n low mid-frame aborts immediately to reset values. The memory transaction is dropped; memory-side idempotence is required.

Optional Feature:
- Macro: SAD_COLLECT_THRESH_EN.
- Defined:
  - Adds input Thresh [SAD_W] and outputs Hit_Count [8] and Hit.
  - Hit_Count counts accepted SADs strictly below Thresh; it clears on Start.
  - Hit is a registered flag set when any accepted SAD is below Thresh; it clears on Start.
  - Both hold after Done.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package sad_pkg:
  - SAD_W, IDX_W and NUM_BLOCKS_MAX = 128.
  - Control FSM and writer FSM state encodings: IDLE/RUN/FIN as 2-bit, W_IDLE/W_REQ as 1-bit.
  - SAD_MAX constant (all ones).
- One sub-module: sad_result_fifo.
  - Synchronous FIFO parameterised by depth and width (IDX_W+SAD_W).
  - Provides full/empty flags and async active-low reset.

Test Plan:
- Basic frame:
  - Stimulus: Start, Num_Blocks=4; send SADs 50, 20, 35, 20 at idx 0..3; O_Ack one cycle after each O_En.
  - Response: writes addr0=50, addr1=20, addr2=35, addr3=20; Done pulses once; Best_SAD=20, Best_Idx=1 (tie keeps earlier).
- Backpressure:
  - Stimulus: Num_Blocks=8, In_Valid held high, O_Ack delayed 6 cycles each.
  - Response: In_Ready drops after 4 buffered plus 1 in flight; no result is lost or reordered; 8 writes in index order.
- Zero blocks:
  - Stimulus: Start with Num_Blocks=0.
  - Response: Done 1 cycle after FIN entry; Best_SAD=32'hFFFF_FFFF, Best_Idx=0; no O_En.
- Over-supply:
  - Stimulus: Num_Blocks=2, 3 valids presented.
  - Response: only 2 accepted; third sees In_Ready=0; Done after the second O_Ack.
- Reset mid-frame:
  - Stimulus: Rst_n low during W_REQ.
  - Response: O_En=0, Busy=0 immediately; a following frame with Num_Blocks=1, SAD=7 gives Best_SAD=7.
- Threshold (SAD_COLLECT_THRESH_EN):
  - Stimulus: Thresh=30 with basic-frame data.
  - Response: Hit_Count=2, Hit=1.
